usr_seq_ctrl: RTL and testbench

Sequencer for one external 4-bit universal shift register. It owns the register's sel, serial and parallel inputs and runs whole serialise (TX) and deserialise (RX) transactions from one command handshake. It returns the final register contents on a response handshake. It sits between a command source and the shift register.

---
 rtl/usr_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_usr_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_seq_ctrl.sv
// Sequencer driving one external universal shift register through whole TX/RX transactions.
// Optional abort support is compiled in with `define USR_SEQ_ABORT_EN.
module usr_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int HOLD_CYC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    output logic             ser_in_req,
    output logic             ser_out,
    output logic             ser_out_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [1:0]       usr_sel,
    output logic             usr_r_serialin,
    output logic             usr_l_serialin,
    output logic [WIDTH-1:0] usr_parallel_in,
    input  logic [WIDTH-1:0] usr_q,
    input  logic             usr_out
`ifdef USR_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             abort_done
`endif
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       HOLD_LAST = 4'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_HOLD,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       hold_q, hold_d;
    logic             sov_q, sov_d;
    logic             abort_done_q, abort_done_d;
    logic             abort_hit;
    logic             shift_bit;

`ifdef USR_SEQ_ABORT_EN
    assign abort_hit  = abort && (state_q == S_LOAD || state_q == S_SHIFT ||
                                  state_q == S_HOLD || state_q == S_DRAIN);
    assign abort_done = abort_done_q;
`else
    assign abort_hit  = 1'b0;
`endif

    // op_q[1] selects RX, op_q[0] selects a left shift
    assign shift_bit       = op_q[1] & ser_in;
    assign usr_parallel_in = data_q;
    assign rsp_data        = rsp_data_q;
    assign ser_out_valid   = sov_q;
    assign ser_out         = sov_q & usr_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 2'b00;
            data_q       <= '0;
            rsp_data_q   <= '0;
            cnt_q        <= '0;
            hold_q       <= 4'd0;
            sov_q        <= 1'b0;
            abort_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            data_q       <= data_d;
            rsp_data_q   <= rsp_data_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            sov_q        <= sov_d;
            abort_done_q <= abort_done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        data_d         = data_q;
        rsp_data_d     = rsp_data_q;
        cnt_d          = cnt_q;
        hold_d         = hold_q;
        sov_d          = 1'b0;
        abort_done_d   = 1'b0;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        ser_in_req     = 1'b0;
        usr_sel        = 2'b00;
        usr_r_serialin = 1'b0;
        usr_l_serialin = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && cmd_ready) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    cnt_d   = '0;
                    state_d = cmd_op[1] ? S_SHIFT : S_LOAD;
                end
            end
            S_LOAD: begin
                usr_sel = 2'b11;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                usr_sel    = op_q[0] ? 2'b10 : 2'b01;
                ser_in_req = op_q[1];
                sov_d      = ~op_q[1];
                if (op_q[0]) begin
                    usr_l_serialin = shift_bit;
                end else begin
                    usr_r_serialin = shift_bit;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DRAIN;
                end else if (HOLD_CYC > 0) begin
                    hold_d  = 4'd0;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_HOLD: begin
                hold_d = hold_q + 4'd1;
                if (hold_q == HOLD_LAST) begin
                    state_d = S_SHIFT;
                end
            end
            // The register's last shift has settled; capture its contents
            S_DRAIN: begin
                rsp_data_d = usr_q;
                state_d    = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            usr_sel        = 2'b00;
            usr_r_serialin = 1'b0;
            usr_l_serialin = 1'b0;
            ser_in_req     = 1'b0;
            sov_d          = 1'b0;
            rsp_data_d     = rsp_data_q;
            abort_done_d   = 1'b1;
            state_d        = S_IDLE;
        end
    end

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Bench for usr_seq_ctrl: two instances (HOLD_CYC=0 and 2) each driving a behavioural shift register.
module tb_usr_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic [1:0] cmd_op [2];
    logic [3:0] cmd_data [2];
    logic       ser_in [2];
    logic       ser_in_req [2];
    logic       ser_out [2];
    logic       sov [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic [3:0] rsp_data [2];
    logic [1:0] usr_sel [2];
    logic       rsi [2];
    logic       lsi [2];
    logic [3:0] pin [2];
    logic [3:0] mq [2];
    logic       mout [2];
`ifdef USR_SEQ_ABORT_EN
    logic       abort0;
    logic       abort_done0;
    logic       abort1;
    logic       abort_done1;
`endif

    int errors = 0;
    int checks = 0;

    bit       bq0 [$];
    bit       bq1 [$];
    bit       rxq0 [$];
    bit [3:0] rq0 [$];
    bit [3:0] rq1 [$];

    always #5 clk = ~clk;

    usr_seq_ctrl #(.WIDTH(4), .HOLD_CYC(0)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_op(cmd_op[0]), .cmd_data(cmd_data[0]),
        .ser_in(ser_in[0]), .ser_in_req(ser_in_req[0]),
        .ser_out(ser_out[0]), .ser_out_valid(sov[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .usr_sel(usr_sel[0]), .usr_r_serialin(rsi[0]), .usr_l_serialin(lsi[0]),
        .usr_parallel_in(pin[0]), .usr_q(mq[0]), .usr_out(mout[0])
`ifdef USR_SEQ_ABORT_EN
        , .abort(abort0), .abort_done(abort_done0)
`endif
    );

    usr_seq_ctrl #(.WIDTH(4), .HOLD_CYC(2)) dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_op(cmd_op[1]), .cmd_data(cmd_data[1]),
        .ser_in(ser_in[1]), .ser_in_req(ser_in_req[1]),
        .ser_out(ser_out[1]), .ser_out_valid(sov[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .usr_sel(usr_sel[1]), .usr_r_serialin(rsi[1]), .usr_l_serialin(lsi[1]),
        .usr_parallel_in(pin[1]), .usr_q(mq[1]), .usr_out(mout[1])
`ifdef USR_SEQ_ABORT_EN
        , .abort(abort1), .abort_done(abort_done1)
`endif
    );

    // Behavioural universal shift register with a registered shift-out bit
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            case (usr_sel[k])
                2'b01: begin mq[k] <= {rsi[k], mq[k][3:1]}; mout[k] <= mq[k][0]; end
                2'b10: begin mq[k] <= {mq[k][2:0], lsi[k]}; mout[k] <= mq[k][3]; end
                2'b11: mq[k] <= pin[k];
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor and RX serial source, sampled on the falling edge
    always @(negedge clk) begin
        if (sov[0]) begin
            if (bq0.size() == 0) chk("unexpected_bit0", 1, 0);
            else chk("ser_out0", ser_out[0], bq0.pop_front());
        end
        if (sov[1]) begin
            if (bq1.size() == 0) chk("unexpected_bit1", 1, 0);
            else chk("ser_out1", ser_out[1], bq1.pop_front());
        end
        if (rsp_valid[0] && rsp_ready[0]) begin
            if (rq0.size() == 0) chk("unexpected_rsp0", 1, 0);
            else chk("rsp_data0", rsp_data[0], rq0.pop_front());
        end
        if (rsp_valid[1] && rsp_ready[1]) begin
            if (rq1.size() == 0) chk("unexpected_rsp1", 1, 0);
            else chk("rsp_data1", rsp_data[1], rq1.pop_front());
        end
        if (ser_in_req[0]) ser_in[0] = (rxq0.size() != 0) ? rxq0.pop_front() : 1'b0;
        ser_in[1] = 1'b0;
    end

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] rx;    // rx[i] is the i-th serial bit supplied
        logic [3:0] bits;  // bits[i] is the i-th bit expected on ser_out
        logic [3:0] rsp;
        int         lat;
        logic [1:0] sel1;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one step after a rising edge; that cycle is the accept cycle 0
    task automatic do_txn(input vec_t v);
        int c;
        if (!v.op[1]) for (int i = 0; i < 4; i++) bq0.push_back(v.bits[i]);
        else          for (int i = 0; i < 4; i++) rxq0.push_back(v.rx[i]);
        rq0.push_back(v.rsp);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = v.op;
        cmd_data[0]  = v.data;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready[0], 1);
        tick();
        cmd_valid[0] = 1'b0;
        c = 1;
        while (c < 40) begin
            @(negedge clk);
            if (c == 1) chk("usr_sel_c1", usr_sel[0], v.sel1);
            if (c == 2) chk("sov_c2", sov[0], 0);
            if (c == 3) chk("sov_c3", sov[0], !v.op[1]);
            if (rsp_valid[0]) break;
            chk("cmd_ready_busy", cmd_ready[0], 0);
            tick();
            c++;
        end
        chk("rsp_latency", c, v.lat);
        tick();
    endtask

    vec_t vecs [6];
    logic [1:0] hold_sel [12] = '{2'b11, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00,
                                  2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        vecs[0] = '{op: 2'b00, data: 4'b1011, rx: 4'b0000, bits: 4'b1011, rsp: 4'b0000, lat: 7, sel1: 2'b11};
        vecs[1] = '{op: 2'b01, data: 4'b1011, rx: 4'b0000, bits: 4'b1101, rsp: 4'b0000, lat: 7, sel1: 2'b11};
        vecs[2] = '{op: 2'b10, data: 4'b1111, rx: 4'b0011, bits: 4'b0000, rsp: 4'b0011, lat: 6, sel1: 2'b01};
        vecs[3] = '{op: 2'b11, data: 4'b0000, rx: 4'b0011, bits: 4'b0000, rsp: 4'b1100, lat: 6, sel1: 2'b10};
        vecs[4] = '{op: 2'b00, data: 4'b0101, rx: 4'b0000, bits: 4'b0101, rsp: 4'b0000, lat: 7, sel1: 2'b11};
        vecs[5] = '{op: 2'b10, data: 4'b0000, rx: 4'b1101, bits: 4'b0000, rsp: 4'b1101, lat: 6, sel1: 2'b01};

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd_op[k] = 2'b00; cmd_data[k] = 4'h0; rsp_ready[k] = 1'b1;
        end
`ifdef USR_SEQ_ABORT_EN
        abort0 = 1'b0;
        abort1 = 1'b0;
`endif
        #2;
        chk("rst_cmd_ready", cmd_ready[0], 0);
        chk("rst_usr_sel", usr_sel[0], 0);
        chk("rst_serialin", {rsi[0], lsi[0]}, 0);
        chk("rst_parallel_in", pin[0], 0);
        chk("rst_rsp", {rsp_valid[0], rsp_data[0]}, 0);
        chk("rst_sov_req", {sov[0], ser_in_req[0]}, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) do_txn(vecs[i]);

        // Spaced shifts, then a stalled response with a command pending
        for (int i = 0; i < 4; i++) bq1.push_back(i == 1 || i == 2);
        rq1.push_back(4'b0000);
        rsp_ready[1] = 1'b0;
        cmd_valid[1] = 1'b1;
        cmd_op[1]    = 2'b00;
        cmd_data[1]  = 4'b0110;
        @(negedge clk);
        chk("hold_cmd_ready", cmd_ready[1], 1);
        tick();
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk("hold_usr_sel", usr_sel[1], hold_sel[c-1]);
            tick();
        end
        for (int c = 13; c <= 17; c++) begin
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid[1], 1);
            chk("stall_rsp_data", rsp_data[1], 0);
            chk("stall_cmd_ready", cmd_ready[1], 0);
            tick();
        end
        cmd_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        tick();
        @(negedge clk);
        chk("after_rsp_valid", rsp_valid[1], 0);
        chk("after_cmd_ready", cmd_ready[1], 1);
        tick();

        // Reset during the third SHIFT of an RX
        rxq0.push_back(1'b1); rxq0.push_back(1'b0); rxq0.push_back(1'b1);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 2'b10;
        tick();
        cmd_valid[0] = 1'b0;
        tick();
        tick();
        chk("third_shift_sel", usr_sel[0], 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_usr_sel", usr_sel[0], 0);
        chk("midrst_serialin", {rsi[0], lsi[0]}, 0);
        chk("midrst_parallel", pin[0], 0);
        chk("midrst_rsp", {rsp_valid[0], rsp_data[0]}, 0);
        chk("midrst_sov_req", {sov[0], ser_in_req[0]}, 0);
        chk("midrst_cmd_ready", cmd_ready[0], 0);
        tick();
        rst = 1'b0;
        rxq0.delete();
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready[0], 1);
        chk("post_rst_no_rsp", rsp_valid[0], 0);
        tick();
        v = '{op: 2'b00, data: 4'b1000, rx: 4'b0000, bits: 4'b1000, rsp: 4'b0000, lat: 7, sel1: 2'b11};
        do_txn(v);

`ifdef USR_SEQ_ABORT_EN
        rxq0.push_back(1'b1); rxq0.push_back(1'b1);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = 2'b10;
        tick();
        cmd_valid[0] = 1'b0;
        tick();
        abort0 = 1'b1;
        @(negedge clk);
        chk("abort_usr_sel", usr_sel[0], 0);
        chk("abort_ser_in_req", ser_in_req[0], 0);
        tick();
        abort0 = 1'b0;
        @(negedge clk);
        chk("abort_done_pulse", abort_done0, 1);
        chk("abort_idle", cmd_ready[0], 1);
        tick();
        @(negedge clk);
        chk("abort_done_clear", abort_done0, 0);
        chk("abort_no_rsp", rsp_valid[0], 0);
        chk("abort_done_other", abort_done1, 0);
        rxq0.delete();
        tick();
`endif

        repeat (3) tick();
        chk("bits0_drained", bq0.size(), 0);
        chk("bits1_drained", bq1.size(), 0);
        chk("rsp_drained", rq0.size() + rq1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
